// File: rtl/dyn_delay_ctrl_if.sv
// Host-side configuration/trigger bus and IDELAYE2 control outputs of dyn_delay_ctrl.
// The host drives the master modport; the tap sequencer sits on the slave modport.
interface dyn_delay_ctrl_if #(
  parameter int TAP_W = 5
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_sweep;
  logic [TAP_W-1:0] cfg_lo;
  logic [TAP_W-1:0] cfg_hi;
  logic [TAP_W-1:0] cfg_step;
  logic             trig;
  logic [TAP_W-1:0] tap_out;
  logic             ldpipeen;
  logic             ld;
  logic             tap_valid;
  logic             wrap;
  logic             trig_miss;

  modport master (
    output cfg_valid, cfg_sweep, cfg_lo, cfg_hi, cfg_step, trig,
    input  cfg_ready, tap_out, ldpipeen, ld, tap_valid, wrap, trig_miss
  );

  modport slave (
    input  cfg_valid, cfg_sweep, cfg_lo, cfg_hi, cfg_step, trig,
    output cfg_ready, tap_out, ldpipeen, ld, tap_valid, wrap, trig_miss
  );
endinterface

// File: rtl/dyn_delay_ctrl.sv
// Tap-value sequencer for an IDELAYE2 in VAR_LOAD_PIPE mode: loads taps via LDPIPEEN then LD,
// waits a settle time, and optionally sweeps the tap on each trigger.
module dyn_delay_ctrl #(
  parameter int TAP_W      = 5,
  parameter int SETTLE_CYC = 16
) (
  input  logic                  clk_in,
  input  logic                  rstn,
  input  logic                  idly_rdy,
  dyn_delay_ctrl_if.slave       bus
);

  typedef enum logic [2:0] {
    ST_WAIT_RDY = 3'd0,
    ST_PIPE     = 3'd1,
    ST_LOAD     = 3'd2,
    ST_SETTLE   = 3'd3,
    ST_READY    = 3'd4
  } state_t;

  localparam logic [7:0]       SETTLE_INIT = 8'(SETTLE_CYC - 1);
  localparam logic [TAP_W-1:0] TAP_ZERO    = {TAP_W{1'b0}};
  localparam logic [TAP_W-1:0] TAP_ONE     = {{(TAP_W-1){1'b0}}, 1'b1};

  logic [1:0]       sync_q, sync_d;
  state_t           state_q, state_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic [TAP_W-1:0] lo_q, lo_d;
  logic [TAP_W-1:0] hi_q, hi_d;
  logic [TAP_W-1:0] step_q, step_d;
  logic             sweep_q, sweep_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ld_q, ld_d;
  logic             ldpipeen_q, ldpipeen_d;
  logic             tap_valid_q, tap_valid_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic             wrap_q, wrap_d;
  logic             trig_miss_q, trig_miss_d;

  logic             rdy_s;
  logic             cfg_hs_s;
  logic [TAP_W:0]   next_tap_s;

  assign rdy_s      = sync_q[1];
  assign cfg_hs_s   = bus.cfg_valid & cfg_ready_q;
  // One spare bit so tap + step can never wrap silently before the limit compare.
  assign next_tap_s = {1'b0, tap_q} + {1'b0, step_q};

  // Two-flop synchroniser for the asynchronous IDELAYCTRL ready.
  always_comb begin
    sync_d = {sync_q[0], idly_rdy};
  end

  // Sequencer next-state, tap selection, configuration capture and strobe generation.
  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    step_d      = step_q;
    sweep_d     = sweep_q;
    cnt_d       = cnt_q;
    wrap_d      = 1'b0;
    trig_miss_d = 1'b0;

    case (state_q)
      ST_WAIT_RDY: begin
        trig_miss_d = bus.trig;
        if (rdy_s) begin
          state_d = ST_PIPE;
        end else begin
          state_d = ST_WAIT_RDY;
        end
      end
      ST_PIPE: begin
        trig_miss_d = bus.trig;
        cnt_d       = SETTLE_INIT;
        state_d     = ST_LOAD;
      end
      ST_LOAD: begin
        trig_miss_d = bus.trig;
        if (cnt_q == 8'd0) begin
          state_d = ST_READY;
        end else begin
          cnt_d   = cnt_q - 8'd1;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        trig_miss_d = bus.trig;
        if (cnt_q == 8'd0) begin
          state_d = ST_READY;
        end else begin
          cnt_d   = cnt_q - 8'd1;
          state_d = ST_SETTLE;
        end
      end
      ST_READY: begin
        if (cfg_hs_s) begin
          // A visible handshake is always honoured, even if ready is dropping this cycle.
          lo_d        = bus.cfg_lo;
          sweep_d     = bus.cfg_sweep;
          tap_d       = bus.cfg_lo;
          trig_miss_d = bus.trig;
          state_d     = ST_PIPE;
          if (bus.cfg_lo > bus.cfg_hi) begin
            hi_d = bus.cfg_lo;
          end else begin
            hi_d = bus.cfg_hi;
          end
          if (bus.cfg_step == TAP_ZERO) begin
            step_d = TAP_ONE;
          end else begin
            step_d = bus.cfg_step;
          end
        end else if (bus.trig && !rdy_s) begin
          trig_miss_d = 1'b1;
        end else if (bus.trig && sweep_q) begin
          state_d = ST_PIPE;
          if (next_tap_s > {1'b0, hi_q}) begin
            tap_d  = lo_q;
            wrap_d = 1'b1;
          end else begin
            tap_d  = next_tap_s[TAP_W-1:0];
            wrap_d = 1'b0;
          end
        end else begin
          state_d = ST_READY;
        end
      end
      default: begin
        state_d = ST_WAIT_RDY;
      end
    endcase

    // Losing the delay controller aborts any load; tap and cfg are kept for the reload.
    if (!rdy_s) begin
      state_d = ST_WAIT_RDY;
    end else begin
      state_d = state_d;
    end
  end

  // Registered strobes follow directly from the state being entered.
  always_comb begin
    ldpipeen_d  = (state_d == ST_PIPE);
    ld_d        = (state_d == ST_LOAD);
    tap_valid_d = (state_d == ST_READY);
    cfg_ready_d = (state_d == ST_READY);
  end

  // State, configuration and output registers.
  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      sync_q      <= 2'b00;
      state_q     <= ST_WAIT_RDY;
      tap_q       <= TAP_ZERO;
      lo_q        <= TAP_ZERO;
      hi_q        <= TAP_ZERO;
      step_q      <= TAP_ONE;
      sweep_q     <= 1'b0;
      cnt_q       <= 8'd0;
      ld_q        <= 1'b0;
      ldpipeen_q  <= 1'b0;
      tap_valid_q <= 1'b0;
      cfg_ready_q <= 1'b0;
      wrap_q      <= 1'b0;
      trig_miss_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      tap_q       <= tap_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      step_q      <= step_d;
      sweep_q     <= sweep_d;
      cnt_q       <= cnt_d;
      ld_q        <= ld_d;
      ldpipeen_q  <= ldpipeen_d;
      tap_valid_q <= tap_valid_d;
      cfg_ready_q <= cfg_ready_d;
      wrap_q      <= wrap_d;
      trig_miss_q <= trig_miss_d;
    end
  end

  assign bus.tap_out   = tap_q;
  assign bus.ldpipeen  = ldpipeen_q;
  assign bus.ld        = ld_q;
  assign bus.tap_valid = tap_valid_q;
  assign bus.cfg_ready = cfg_ready_q;
  assign bus.wrap      = wrap_q;
  assign bus.trig_miss = trig_miss_q;

endmodule

// File: tb/tb_dyn_delay_ctrl.sv
// Directed bench for dyn_delay_ctrl: load sequencing, sweep/wrap arithmetic, trigger drops,
// ready loss and asynchronous reset, with SETTLE_CYC = 16.
module tb_dyn_delay_ctrl;

  logic clk = 1'b0;
  logic rstn;
  logic idly_rdy;
  int   nvec = 0;
  int   nerr = 0;
  int   n;

  dyn_delay_ctrl_if #(.TAP_W(5)) bus ();

  dyn_delay_ctrl #(.TAP_W(5), .SETTLE_CYC(16)) dut (
    .clk_in   (clk),
    .rstn     (rstn),
    .idly_rdy (idly_rdy),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the first PIPE cycle; walks LOAD and the 16-cycle settle.
  task automatic expect_load(input string tag, input logic [4:0] t);
    chk({tag, "_pipe"}, {31'd0, bus.ldpipeen}, 32'd1);
    chk({tag, "_pipe_ld"}, {31'd0, bus.ld}, 32'd0);
    chk({tag, "_pipe_tap"}, {27'd0, bus.tap_out}, {27'd0, t});
    tick();
    chk({tag, "_ld"}, {31'd0, bus.ld}, 32'd1);
    chk({tag, "_ld_pipe"}, {31'd0, bus.ldpipeen}, 32'd0);
    chk({tag, "_ld_tap"}, {27'd0, bus.tap_out}, {27'd0, t});
    chk({tag, "_wrap_clr"}, {31'd0, bus.wrap}, 32'd0);
    repeat (15) tick();
    chk({tag, "_tv_early"}, {31'd0, bus.tap_valid}, 32'd0);
    chk({tag, "_settle_tap"}, {27'd0, bus.tap_out}, {27'd0, t});
    tick();
    chk({tag, "_tv"}, {31'd0, bus.tap_valid}, 32'd1);
    chk({tag, "_rdy"}, {31'd0, bus.cfg_ready}, 32'd1);
  endtask

  task automatic do_cfg(input logic sw, input logic [4:0] lo, input logic [4:0] hi,
                        input logic [4:0] st);
    bus.cfg_sweep = sw;
    bus.cfg_lo    = lo;
    bus.cfg_hi    = hi;
    bus.cfg_step  = st;
    bus.cfg_valid = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
    chk("cfg_tv_drop", {31'd0, bus.tap_valid}, 32'd0);
  endtask

  task automatic do_trig();
    bus.trig = 1'b1;
    tick();
    bus.trig = 1'b0;
  endtask

  initial begin
    rstn          = 1'b0;
    idly_rdy      = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_sweep = 1'b0;
    bus.cfg_lo    = 5'd0;
    bus.cfg_hi    = 5'd0;
    bus.cfg_step  = 5'd0;
    bus.trig      = 1'b0;

    // 1. power-up
    repeat (5) tick();
    chk("rst_tap", {27'd0, bus.tap_out}, 32'd0);
    chk("rst_ld", {31'd0, bus.ld}, 32'd0);
    chk("rst_pipe", {31'd0, bus.ldpipeen}, 32'd0);
    chk("rst_tv", {31'd0, bus.tap_valid}, 32'd0);
    chk("rst_rdy", {31'd0, bus.cfg_ready}, 32'd0);
    chk("rst_wrap", {31'd0, bus.wrap}, 32'd0);
    chk("rst_miss", {31'd0, bus.trig_miss}, 32'd0);
    rstn     = 1'b1;
    idly_rdy = 1'b1;
    tick();
    tick();
    chk("t1_sync_lat", {31'd0, bus.ldpipeen}, 32'd0);
    tick();
    expect_load("t1", 5'd0);

    // 2. fixed tap, trig ignored
    do_cfg(1'b0, 5'd10, 5'd20, 5'd3);
    expect_load("t2", 5'd10);
    do_trig();
    chk("t2_trig_miss", {31'd0, bus.trig_miss}, 32'd0);
    chk("t2_trig_pipe", {31'd0, bus.ldpipeen}, 32'd0);
    chk("t2_trig_tap", {27'd0, bus.tap_out}, 32'd10);
    chk("t2_trig_tv", {31'd0, bus.tap_valid}, 32'd1);
    tick();
    chk("t2_trig_ld", {31'd0, bus.ld}, 32'd0);

    // 3. sweep 28..31 step 2, then carry case
    do_cfg(1'b1, 5'd28, 5'd31, 5'd2);
    expect_load("t3a", 5'd28);
    do_trig();
    chk("t3_wrap0", {31'd0, bus.wrap}, 32'd0);
    expect_load("t3b", 5'd30);
    do_trig();
    chk("t3_wrap1", {31'd0, bus.wrap}, 32'd1);
    expect_load("t3c", 5'd28);
    do_trig();
    chk("t3_wrap2", {31'd0, bus.wrap}, 32'd0);
    expect_load("t3d", 5'd30);
    do_cfg(1'b1, 5'd31, 5'd31, 5'd31);
    expect_load("t3e", 5'd31);
    do_trig();
    chk("t3_carry_wrap", {31'd0, bus.wrap}, 32'd1);
    expect_load("t3f", 5'd31);

    // 4. lo > hi, step 0
    do_cfg(1'b1, 5'd12, 5'd5, 5'd1);
    expect_load("t4a", 5'd12);
    do_trig();
    chk("t4_hi_wrap", {31'd0, bus.wrap}, 32'd1);
    expect_load("t4b", 5'd12);
    do_cfg(1'b1, 5'd3, 5'd10, 5'd0);
    expect_load("t4c", 5'd3);
    do_trig();
    chk("t4_step0_wrap", {31'd0, bus.wrap}, 32'd0);
    expect_load("t4d", 5'd4);

    // 5. trig and cfg during SETTLE
    do_trig();
    chk("t5_pipe_tap", {27'd0, bus.tap_out}, 32'd5);
    tick();
    tick();
    bus.trig      = 1'b1;
    bus.cfg_sweep = 1'b0;
    bus.cfg_lo    = 5'd7;
    bus.cfg_hi    = 5'd9;
    bus.cfg_step  = 5'd1;
    bus.cfg_valid = 1'b1;
    tick();
    bus.trig = 1'b0;
    chk("t5_miss", {31'd0, bus.trig_miss}, 32'd1);
    chk("t5_rdy_lo", {31'd0, bus.cfg_ready}, 32'd0);
    chk("t5_tap_hold", {27'd0, bus.tap_out}, 32'd5);
    tick();
    chk("t5_miss_clr", {31'd0, bus.trig_miss}, 32'd0);
    n = 0;
    while (bus.tap_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("t5_held_tv", {31'd0, bus.tap_valid}, 32'd1);
    chk("t5_held_tap", {27'd0, bus.tap_out}, 32'd5);
    chk("t5_settle_len", n, 32'd13);
    tick();
    bus.cfg_valid = 1'b0;
    expect_load("t5c", 5'd7);

    // simultaneous cfg and trig: cfg wins
    bus.cfg_sweep = 1'b1;
    bus.cfg_lo    = 5'd22;
    bus.cfg_hi    = 5'd25;
    bus.cfg_step  = 5'd1;
    bus.cfg_valid = 1'b1;
    bus.trig      = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
    bus.trig      = 1'b0;
    chk("t5_both_miss", {31'd0, bus.trig_miss}, 32'd1);
    chk("t5_both_tap", {27'd0, bus.tap_out}, 32'd22);
    chk("t5_both_pipe", {31'd0, bus.ldpipeen}, 32'd1);

    // 6. drop ready mid-SETTLE at tap 22
    tick();
    tick();
    tick();
    tick();
    idly_rdy = 1'b0;
    repeat (3) tick();
    chk("t6_tv", {31'd0, bus.tap_valid}, 32'd0);
    chk("t6_rdy", {31'd0, bus.cfg_ready}, 32'd0);
    chk("t6_tap", {27'd0, bus.tap_out}, 32'd22);
    repeat (20) tick();
    chk("t6_wait_tv", {31'd0, bus.tap_valid}, 32'd0);
    chk("t6_wait_ld", {31'd0, bus.ld}, 32'd0);
    idly_rdy = 1'b1;
    tick();
    tick();
    chk("t6_resync", {31'd0, bus.ldpipeen}, 32'd0);
    tick();
    expect_load("t6r", 5'd22);
    idly_rdy = 1'b0;
    tick();
    tick();
    chk("t6_ready_hold", {31'd0, bus.tap_valid}, 32'd1);
    tick();
    chk("t6_ready_drop", {31'd0, bus.tap_valid}, 32'd0);
    idly_rdy = 1'b1;
    repeat (3) tick();
    expect_load("t6r2", 5'd22);

    // async reset mid-LOAD
    do_trig();
    chk("t7_step_tap", {27'd0, bus.tap_out}, 32'd23);
    tick();
    chk("t7_in_load", {31'd0, bus.ld}, 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("t7_ld", {31'd0, bus.ld}, 32'd0);
    chk("t7_tap", {27'd0, bus.tap_out}, 32'd0);
    chk("t7_tv", {31'd0, bus.tap_valid}, 32'd0);
    chk("t7_rdy", {31'd0, bus.cfg_ready}, 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    tick();
    chk("t7_resync", {31'd0, bus.ldpipeen}, 32'd0);
    tick();
    expect_load("t7", 5'd0);
    do_trig();
    chk("t7_sweep_off", {31'd0, bus.ldpipeen}, 32'd0);
    chk("t7_sweep_tap", {27'd0, bus.tap_out}, 32'd0);
    chk("t7_sweep_miss", {31'd0, bus.trig_miss}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
